// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall controller for the in-order pipeline.
// Tracks in-flight destinations from EXE to WB and produces freeze/flush/mem_freeze and forwarding selects.
module pipe_hazard_ctrl #(
  parameter int REGFILE_ADDRESS_LEN = 4,
  parameter int DEPTH               = 3,
  parameter int FORWARD_EN          = 1,
  parameter int WB_BYPASS           = 0,
  parameter int STAT_LEN            = 16,
  parameter int MEM_TIMEOUT         = 15
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           id_valid,
  input  logic [REGFILE_ADDRESS_LEN-1:0] id_src1,
  input  logic                           id_src1_used,
  input  logic [REGFILE_ADDRESS_LEN-1:0] id_src2,
  input  logic                           id_src2_used,
  input  logic [REGFILE_ADDRESS_LEN-1:0] id_dest,
  input  logic                           id_wb_en,
  input  logic                           id_mem_read,
  input  logic                           branch_taken,
  input  logic                           mem_req,
  input  logic                           mem_ready,
  output logic                           freeze,
  output logic                           flush,
  output logic                           mem_freeze,
  output logic [2:0]                     fwd_sel1,
  output logic [2:0]                     fwd_sel2,
  output logic [STAT_LEN-1:0]            stall_count,
  output logic [STAT_LEN-1:0]            flush_count,
  output logic                           timeout_err
);

  localparam int AW     = REGFILE_ADDRESS_LEN;
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  logic [DEPTH-1:0]         sb_valid;
  logic [DEPTH-1:0]         sb_load;
  logic [DEPTH-1:0][AW-1:0] sb_dest;
  logic [DEPTH-1:0]         match1;
  logic [DEPTH-1:0]         match2;
  logic [DEPTH-1:0]         fwd_ok;
  logic                     hazard;
  logic [WAIT_W-1:0]        wait_cnt;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      match1[k] = sb_valid[k] & (sb_dest[k] == id_src1) & id_src1_used & id_valid;
      match2[k] = sb_valid[k] & (sb_dest[k] == id_src2) & id_src2_used & id_valid;
      // A load in EXE has no data yet; the WB entry is read straight from the regfile when bypassed.
      fwd_ok[k] = ~((k == 0) & sb_load[0]) & ~((WB_BYPASS != 0) & (k == DEPTH - 1));
    end
  end

  always_comb begin
    hazard   = 1'b0;
    fwd_sel1 = 3'd0;
    fwd_sel2 = 3'd0;
    if (FORWARD_EN != 0) begin
      hazard = sb_load[0] & (match1[0] | match2[0]);
      // Descending scan so the youngest matching entry is assigned last.
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (match1[k] && fwd_ok[k]) fwd_sel1 = 3'(k + 1);
        if (match2[k] && fwd_ok[k]) fwd_sel2 = 3'(k + 1);
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if ((match1[k] | match2[k]) && !((WB_BYPASS != 0) && (k == DEPTH - 1)))
          hazard = 1'b1;
      end
    end
  end

  assign mem_freeze = mem_req & ~mem_ready;
  assign flush      = branch_taken & ~mem_freeze;
  assign freeze     = hazard & ~flush & ~mem_freeze;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_valid <= '0;
      sb_load  <= '0;
      sb_dest  <= '0;
    end else if (!mem_freeze) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        sb_valid[k] <= sb_valid[k-1];
        sb_load[k]  <= sb_load[k-1];
        sb_dest[k]  <= sb_dest[k-1];
      end
      sb_valid[0] <= id_valid & id_wb_en & ~freeze & ~flush;
      sb_load[0]  <= id_mem_read;
      sb_dest[0]  <= id_dest;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
      flush_count <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if ((freeze | mem_freeze) && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
      if (flush && (flush_count != '1))
        flush_count <= flush_count + 1'b1;
      if (!mem_freeze) begin
        wait_cnt <= '0;
      end else begin
        if (wait_cnt != '1)
          wait_cnt <= wait_cnt + 1'b1;
        // Sets on the edge where wait_cnt steps onto MEM_TIMEOUT.
        if (wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1))
          timeout_err <= 1'b1;
      end
    end
  end

endmodule
